mix_columns_seq: RTL

//  Iterative AES MixColumns stage, directly downstream of shiftRows in the round datapath.
//  - Captures one 128-bit state via valid/ready handshake.
//  - Transforms COLS_PER_CYCLE columns per clock and presents the result with valid/ready.
//  - Rounds 1..9: applies MixColumns.
//  - Round 10 (no MixColumns) and any round outside 1..9: registered pass-through.

---
 rtl/mix_columns_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// -----------------------------------------------------------------------------
// mix_columns_seq
//   Iterative AES MixColumns stage that sits after shiftRows in the round
//   datapath. It accepts one 128-bit state over a valid/ready handshake.
//   For rounds 1..9 it transforms COLS_PER_CYCLE columns per clock and then
//   presents the result. Round 10, and any round outside 1..9, passes the
//   state straight through one register.
//
//   Parameters
//     COLS_PER_CYCLE : columns transformed per CALC cycle (1, 2 or 4)
//
//   Ports
//     clk       : clock, rising edge
//     rst_n     : synchronous reset, active low
//     round     : round number, sampled together with text_in on accept
//     in_valid  : text_in/round valid
//     in_ready  : stage can accept (IDLE only, forced low during reset)
//     text_in   : 128-bit state from shiftRows
//     out_valid : text_out valid
//     out_ready : consumer accepts text_out
//     text_out  : registered result
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for an input state, in_ready high
//   CALC  | transforming columns cnt..cnt+COLS_PER_CYCLE-1 each cycle
//   DONE  | text_out valid, held until out_ready
// -----------------------------------------------------------------------------
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   round,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   text_out_q, text_out_d;

  logic [2:0]     cnt_sum;
  logic [127:0]   work_mixed;
  logic           accept;
  logic           mix_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign text_out  = text_out_q;
  assign accept    = in_valid && in_ready;
  assign mix_round = (round >= 4'd1) && (round <= 4'd9);

  // Column window for this CALC cycle. cnt_sum[2] marks that column 3 is
  // finished; the low bits are the wrapped next counter value.
  always_comb begin
    cnt_sum    = {1'b0, cnt_q} + 3'(COLS_PER_CYCLE);
    work_mixed = work_q;
    for (int c = 0; c < 4; c++) begin
      if ((3'(c) >= {1'b0, cnt_q}) && (3'(c) < cnt_sum)) begin
        work_mixed[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    text_out_d = text_out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d = text_in;
          cnt_d  = 2'd0;
          if (mix_round) begin
            state_d = CALC;
          end else begin
            text_out_d = text_in;
            state_d    = DONE;
          end
        end
      end
      CALC: begin
        work_d = work_mixed;
        cnt_d  = cnt_sum[1:0];
        if (cnt_sum[2]) begin
          text_out_d = work_mixed;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      work_q     <= '0;
      text_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      text_out_q <= text_out_d;
    end
  end

endmodule
